// File: rtl/fft_control_param.sv
// Radix-4 FFT/FHT control unit for N = 4^STAGES points over four memory banks
// of depth D = 4^(STAGES-1). Walks every stage through a READ phase (one read
// address set per unstalled cycle) and a DRAIN phase of PIPE_LAT cycles. The
// drain lets the butterfly pipeline finish writing one stage before the next
// stage starts reading.
//
// Ports:
//   iCLK, iRESET (async, active low)
//   iSTART  start request, sampled only in IDLE
//   iSTOP   abort to IDLE, highest priority
//   iHOLD   read stall, freezes the read counter (READ only)
//   oADDR_RD_0..3, oBANK_RD_ROT, oRD_VALID   per-bank read addresses
//   oADDR_WR, oBANK_WR_ROT, oWE              read side delayed by PIPE_LAT
//   oADDR_COEF                               twiddle ROM address
//   oSOURCE_DATA  1 while stage 0 reads from the input buffer
//   oSTAGE, oRDY, oDONE                      status
module fft_control_param #(
  parameter int STAGES   = 5,
  parameter int A_BIT    = 2*STAGES-2,
  parameter int PIPE_LAT = 6
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      iSTART,
  input  logic                      iSTOP,
  input  logic                      iHOLD,
  output logic [A_BIT-1:0]          oADDR_RD_0,
  output logic [A_BIT-1:0]          oADDR_RD_1,
  output logic [A_BIT-1:0]          oADDR_RD_2,
  output logic [A_BIT-1:0]          oADDR_RD_3,
  output logic [1:0]                oBANK_RD_ROT,
  output logic                      oRD_VALID,
  output logic [A_BIT-1:0]          oADDR_WR,
  output logic [1:0]                oBANK_WR_ROT,
  output logic                      oWE,
  output logic [A_BIT-1:0]          oADDR_COEF,
  output logic                      oSOURCE_DATA,
  output logic [$clog2(STAGES)-1:0] oSTAGE,
  output logic                      oRDY,
  output logic                      oDONE
);

  localparam int SW = $clog2(STAGES);
  localparam int D  = 1 << A_BIT;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e                        state_q;
  logic [A_BIT:0]                a_q;      // next read index to emit; reaches D when stage fully read
  logic [SW-1:0]                 s_q;
  logic [DW-1:0]                 d_q;
  logic [PIPE_LAT-1:0]           vld_pipe;
  logic [PIPE_LAT-1:0][A_BIT-1:0] adr_pipe;
  logic [PIPE_LAT-1:0][1:0]      rot_pipe;

  // Digit p = STAGES-2-s of a selects the butterfly leg; last stage has none.
  function automatic logic [1:0] rot_of(input logic [A_BIT-1:0] a, input logic [SW-1:0] s);
    logic [1:0] r;
    r = '0;
    for (int j = 0; j < STAGES-1; j++)
      if (int'(s) == STAGES-2-j) r = a[2*j +: 2];
    return r;
  endfunction

  function automatic logic [A_BIT-1:0] rd_addr(input logic [A_BIT-1:0] a, input logic [SW-1:0] s,
                                               input logic [1:0] k);
    logic [A_BIT-1:0] r;
    r = a;
    for (int j = 0; j < STAGES-1; j++)
      if (int'(s) == STAGES-2-j) r[2*j +: 2] = a[2*j +: 2] + k;
    return r;
  endfunction

  // (a mod 4^(STAGES-1-s)) << 2s, naturally zero in the last stage.
  function automatic logic [A_BIT-1:0] coef_of(input logic [A_BIT-1:0] a, input logic [SW-1:0] s);
    logic [A_BIT-1:0] m;
    m = '0;
    for (int j = 0; j < A_BIT; j++)
      if (j < 2*(STAGES-1-int'(s))) m[j] = a[j];
    return m << (2*int'(s));
  endfunction

  logic             kill, emit, rd_done, last_d, last_s;
  logic [A_BIT-1:0] e_a;
  logic [SW-1:0]    e_s;

  assign kill    = iSTOP && (state_q != IDLE);
  assign rd_done = (a_q == (A_BIT+1)'(D));
  assign last_d  = (d_q == DW'(PIPE_LAT-1));
  assign last_s  = (s_q == SW'(STAGES-1));

  // Decide whether the next cycle carries a read, and for which (stage, index).
  // The first read of a stage is issued from IDLE/DRAIN, so iHOLD cannot delay it.
  always_comb begin
    emit = 1'b0;
    e_a  = a_q[A_BIT-1:0];
    e_s  = s_q;
    case (state_q)
      IDLE: begin
        emit = iSTART;
        e_a  = '0;
        e_s  = '0;
      end
      READ:  emit = !rd_done && !iHOLD;
      DRAIN: begin
        emit = last_d && !last_s;
        e_a  = '0;
        e_s  = s_q + SW'(1);
      end
      default: emit = 1'b0;
    endcase
    if (kill) emit = 1'b0;
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q      <= IDLE;
      a_q          <= '0;
      s_q          <= '0;
      d_q          <= '0;
      oRDY         <= 1'b1;
      oDONE        <= 1'b0;
      oSOURCE_DATA <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      if (emit) a_q <= {1'b0, e_a} + (A_BIT+1)'(1);
      if (kill) begin
        state_q      <= IDLE;
        a_q          <= '0;
        s_q          <= '0;
        d_q          <= '0;
        oRDY         <= 1'b1;
        oSOURCE_DATA <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (iSTART) begin
            state_q      <= READ;
            s_q          <= '0;
            oRDY         <= 1'b0;
            oSOURCE_DATA <= 1'b1;
          end
          READ: if (rd_done) begin
            state_q      <= DRAIN;
            d_q          <= '0;
            oSOURCE_DATA <= 1'b0;
          end
          DRAIN: begin
            if (last_d) begin
              if (last_s) begin
                state_q <= DONE;
                oDONE   <= 1'b1;
              end else begin
                state_q <= READ;
                s_q     <= e_s;
              end
            end else begin
              d_q <= d_q + DW'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
            oRDY    <= 1'b1;
            s_q     <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oRD_VALID    <= 1'b0;
      oADDR_RD_0   <= '0;
      oADDR_RD_1   <= '0;
      oADDR_RD_2   <= '0;
      oADDR_RD_3   <= '0;
      oBANK_RD_ROT <= '0;
      oADDR_COEF   <= '0;
    end else begin
      oRD_VALID <= emit;
      if (emit) begin
        oADDR_RD_0   <= rd_addr(e_a, e_s, 2'd0);
        oADDR_RD_1   <= rd_addr(e_a, e_s, 2'd1);
        oADDR_RD_2   <= rd_addr(e_a, e_s, 2'd2);
        oADDR_RD_3   <= rd_addr(e_a, e_s, 2'd3);
        oBANK_RD_ROT <= rot_of(e_a, e_s);
        oADDR_COEF   <= coef_of(e_a, e_s);
      end
    end
  end

  // Write-side delay line; an abort drops every in-flight write.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      vld_pipe <= '0;
      adr_pipe <= '0;
      rot_pipe <= '0;
    end else begin
      vld_pipe[0] <= oRD_VALID && !kill;
      adr_pipe[0] <= oADDR_RD_0;
      rot_pipe[0] <= oBANK_RD_ROT;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1] && !kill;
        adr_pipe[i] <= adr_pipe[i-1];
        rot_pipe[i] <= rot_pipe[i-1];
      end
    end
  end

  assign oWE          = vld_pipe[PIPE_LAT-1];
  assign oADDR_WR     = adr_pipe[PIPE_LAT-1];
  assign oBANK_WR_ROT = rot_pipe[PIPE_LAT-1];
  assign oSTAGE       = s_q;

endmodule
